// File: rtl/rip_bp_update_queue.sv
// In-order queue of predicted conditional branches awaiting resolution.
// Each resolve pops the oldest entry and drives one registered predictor update.
module rip_bp_update_queue #(
   parameter int DEPTH        = 4,
   parameter int INDEX_WIDTH  = 10,
   parameter int WEIGHT_WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [INDEX_WIDTH-1:0]     push_index,
   input  logic [WEIGHT_WIDTH-1:0]    push_weight,
   input  logic                       push_pred,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   input  logic                       flush,
   output logic                       update,
   output logic [INDEX_WIDTH-1:0]     update_index,
   output logic [WEIGHT_WIDTH-1:0]    update_weight,
   output logic                       actual,
   output logic                       mispredict,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [INDEX_WIDTH-1:0]  idx_mem  [DEPTH];
   logic [WEIGHT_WIDTH-1:0] wgt_mem  [DEPTH];
   logic                    pred_mem [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head_nxt;
   logic          pop;
   logic          mis;
   logic          clear;
   logic          do_push;

   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign push_ready = ~rst & ~full;

   assign pop      = resolve_valid & ~empty;
   assign mis      = pop & (pred_mem[head] ^ resolve_taken);
   assign clear    = flush | mis;
   assign do_push  = push_valid & push_ready & ~clear;
   assign head_nxt = pop ? head + AW'(1) : head;

   always_ff @(posedge clk) begin
      if (do_push) begin
         idx_mem[tail]  <= push_index;
         wgt_mem[tail]  <= push_weight;
         pred_mem[tail] <= push_pred;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         update        <= 1'b0;
         update_index  <= '0;
         update_weight <= '0;
         actual        <= 1'b0;
         mispredict    <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         update <= pop;
         if (pop) begin
            update_index  <= idx_mem[head];
            update_weight <= wgt_mem[head];
            actual        <= resolve_taken;
            mispredict    <= mis;
         end
         if (resolve_valid & empty)
            underflow <= 1'b1;
         head <= head_nxt;
         // Dropping wrong-path entries collapses tail onto the post-pop head.
         if (clear) begin
            tail  <= head_nxt;
            count <= '0;
         end else begin
            tail  <= tail + AW'(do_push);
            count <= count + CW'(do_push) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_rip_bp_update_queue.sv
// Directed bench for rip_bp_update_queue.
// Each scenario task drives vectors and checks hand-computed results.
module tb_rip_bp_update_queue;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push_valid = 1'b0;
   logic       push_ready;
   logic [9:0] push_index = '0;
   logic [1:0] push_weight = '0;
   logic       push_pred = 1'b0;
   logic       resolve_valid = 1'b0;
   logic       resolve_taken = 1'b0;
   logic       flush = 1'b0;
   logic       update;
   logic [9:0] update_index;
   logic [1:0] update_weight;
   logic       actual;
   logic       mispredict;
   logic [2:0] count;
   logic       empty;
   logic       full;
   logic       underflow;

   int checks = 0;
   int failures = 0;

   rip_bp_update_queue #(
      .DEPTH(4), .INDEX_WIDTH(10), .WEIGHT_WIDTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_index(push_index), .push_weight(push_weight),
      .push_pred(push_pred),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .flush(flush),
      .update(update), .update_index(update_index),
      .update_weight(update_weight), .actual(actual),
      .mispredict(mispredict), .count(count),
      .empty(empty), .full(full), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_valid = 1'b0;
      resolve_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      push_valid = 1'b1;
      push_index = 10'd99;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (push_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready cyc=%0d got=%0b exp=0", i, push_ready);
         end
         checks++;
         if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL rst_count got=%0d/%0b/%0b exp=0/1/0",
                     count, empty, full);
         end
         checks++;
         if (update !== 1'b0 || underflow !== 1'b0 || mispredict !== 1'b0) begin
            failures++;
            $display("FAIL rst_update got=%0b/%0b/%0b exp=0/0/0",
                     update, underflow, mispredict);
         end
         checks++;
         if (update_index !== 10'd0 || update_weight !== 2'd0 || actual !== 1'b0) begin
            failures++;
            $display("FAIL rst_fields got=%0d/%0d/%0b exp=0/0/0",
                     update_index, update_weight, actual);
         end
      end
      push_valid = 1'b0;
      rst = 1'b0;
      tick();
      checks++;
      if (push_ready !== 1'b1 || count !== 3'd0) begin
         failures++;
         $display("FAIL rst_release got=%0b/%0d exp=1/0", push_ready, count);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 4; i++) begin
         push_valid = 1'b1;
         push_index = 10'(i);
         push_weight = 2'b10;
         push_pred = 1'b1;
         tick();
      end
      checks++;
      if (full !== 1'b1 || count !== 3'd4) begin
         failures++;
         $display("FAIL fd_full got=%0b/%0d exp=1/4", full, count);
      end
      push_index = 10'd5;
      checks++;
      if (push_ready !== 1'b0) begin
         failures++;
         $display("FAIL fd_ready got=%0b exp=0", push_ready);
      end
      // Concurrent push and pop on a full queue: the push is refused.
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         push_valid = 1'b0;
         checks++;
         if (update !== 1'b1 || update_index !== 10'(k)) begin
            failures++;
            $display("FAIL fd_update k=%0d got=%0b/%0d exp=1/%0d",
                     k, update, update_index, k);
         end
         checks++;
         if (mispredict !== 1'b0 || actual !== 1'b1 || update_weight !== 2'b10) begin
            failures++;
            $display("FAIL fd_fields k=%0d got=%0b/%0b/%0d exp=0/1/2",
                     k, mispredict, actual, update_weight);
         end
         checks++;
         if (count !== 3'(4 - k)) begin
            failures++;
            $display("FAIL fd_count k=%0d got=%0d exp=%0d", k, count, 4 - k);
         end
      end
      idle();
      tick();
      checks++;
      if (update !== 1'b0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL fd_end got=%0b/%0b exp=0/1", update, empty);
      end
   endtask

   task automatic test_mispredict();
      for (int i = 7; i <= 9; i++) begin
         push_valid = 1'b1;
         push_index = 10'(i);
         push_weight = 2'b01;
         push_pred = 1'b1;
         tick();
      end
      push_index = 10'd10;
      resolve_valid = 1'b1;
      resolve_taken = 1'b0;
      tick();
      idle();
      checks++;
      if (update !== 1'b1 || update_index !== 10'd7) begin
         failures++;
         $display("FAIL mp_update got=%0b/%0d exp=1/7", update, update_index);
      end
      checks++;
      if (actual !== 1'b0 || mispredict !== 1'b1) begin
         failures++;
         $display("FAIL mp_flags got=%0b/%0b exp=0/1", actual, mispredict);
      end
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL mp_count got=%0d/%0b exp=0/1", count, empty);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (update !== 1'b0 || count !== 3'd0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL mp_quiet got=%0b/%0d/%0b exp=0/0/0",
                     update, count, underflow);
         end
      end
   endtask

   task automatic test_flush_resolve();
      push_valid = 1'b1;
      push_pred = 1'b1;
      push_weight = 2'b11;
      push_index = 10'd3;
      tick();
      push_index = 10'd5;
      tick();
      push_valid = 1'b0;
      flush = 1'b1;
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      tick();
      idle();
      checks++;
      if (update !== 1'b1 || update_index !== 10'd3 || mispredict !== 1'b0) begin
         failures++;
         $display("FAIL fl_update got=%0b/%0d/%0b exp=1/3/0",
                  update, update_index, mispredict);
      end
      checks++;
      if (count !== 3'd0) begin
         failures++;
         $display("FAIL fl_count got=%0d exp=0", count);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (update !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL fl_quiet got=%0b/%0b exp=0/1", update, empty);
         end
      end
   endtask

   task automatic test_wrap();
      push_valid = 1'b1;
      push_index = 10'd0;
      push_weight = 2'd0;
      push_pred = 1'b0;
      tick();
      for (int i = 1; i <= 10; i++) begin
         push_valid = (i <= 9);
         push_index = 10'(i);
         push_weight = 2'(i);
         push_pred = i[0];
         resolve_valid = 1'b1;
         resolve_taken = (i - 1) % 2 == 1;
         tick();
         checks++;
         if (update !== 1'b1 || update_index !== 10'(i - 1)) begin
            failures++;
            $display("FAIL wr_update i=%0d got=%0b/%0d exp=1/%0d",
                     i, update, update_index, i - 1);
         end
         checks++;
         if (update_weight !== 2'(i - 1) || mispredict !== 1'b0) begin
            failures++;
            $display("FAIL wr_fields i=%0d got=%0d/%0b exp=%0d/0",
                     i, update_weight, mispredict, (i - 1) % 4);
         end
         checks++;
         if (count !== ((i <= 9) ? 3'd1 : 3'd0)) begin
            failures++;
            $display("FAIL wr_count i=%0d got=%0d exp=%0d",
                     i, count, (i <= 9) ? 1 : 0);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_underflow();
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      tick();
      idle();
      checks++;
      if (update !== 1'b0 || underflow !== 1'b1) begin
         failures++;
         $display("FAIL uf_set got=%0b/%0b exp=0/1", update, underflow);
      end
      push_valid = 1'b1;
      push_index = 10'd42;
      push_weight = 2'b01;
      push_pred = 1'b0;
      tick();
      push_valid = 1'b0;
      resolve_valid = 1'b1;
      resolve_taken = 1'b0;
      tick();
      idle();
      checks++;
      if (update !== 1'b1 || update_index !== 10'd42 || underflow !== 1'b1) begin
         failures++;
         $display("FAIL uf_hold got=%0b/%0d/%0b exp=1/42/1",
                  update, update_index, underflow);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (underflow !== 1'b0 || update !== 1'b0) begin
         failures++;
         $display("FAIL uf_clear got=%0b/%0b exp=0/0", underflow, update);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_mispredict();
      test_flush_resolve();
      test_wrap();
      test_underflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rip_bp_update_queue.md
# rip_bp_update_queue

In-order queue between the branch predictor's prediction outputs and its training port. At fetch it captures each conditional branch's table index, weight snapshot and predicted direction. When execute resolves the oldest branch, it pops the entry, drives the predictor's update interface one cycle later, and flags mispredictions. On a mispredict it discards all younger (wrong-path) entries.

## Interface
- `DEPTH`, 4: entry count; power of two, ≥2.
- `INDEX_WIDTH`, 10: width of the predictor table index.
- `WEIGHT_WIDTH`, 2: width of the weight snapshot; opaque payload, never interpreted.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `push_valid`  in  1  fetch stage pushes a predicted branch.
- `push_ready`  out  1  entry is accepted; equals `~rst & ~full`.
- `push_index`  in  INDEX_WIDTH  predictor index used for the prediction.
- `push_weight`  in  WEIGHT_WIDTH  weight read at prediction time.
- `push_pred`  in  1  predicted direction (1 = taken).
- `resolve_valid`  in  1  execute resolves the oldest outstanding branch.
- `resolve_taken`  in  1  actual direction of that branch.
- `flush`  in  1  external pipeline flush (trap or redirect); drops all entries.
- `update`  out  1  one-cycle pulse to the predictor's update port.
- `update_index`  out  INDEX_WIDTH  index to train.
- `update_weight`  out  WEIGHT_WIDTH  weight snapshot to train from.
- `actual`  out  1  resolved direction.
- `mispredict`  out  1  qualified by `update`; stored prediction ≠ `actual`.
- `count`  out  $clog2(DEPTH+1)  occupied entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `underflow`  out  1  sticky; set when a resolve arrives while the queue is empty.

## Operation
- Storage is a circular buffer with `head` and `tail` pointers of width log2(DEPTH). The pointers wrap modulo DEPTH. `count` is tracked separately.
- **Push.** When `push_valid & push_ready`, the entry {index, weight, pred} is written at `tail` and `tail` increments.
- **Resolve.** When `resolve_valid & ~empty`:
  - Head is popped.
  - On the next edge: `update`=1, `update_index`/`update_weight` = head fields, `actual` = `resolve_taken`, `mispredict` = `head.pred ^ resolve_taken`.
- **Resolve while empty.** Ignored. `update` stays 0 and `underflow` is set. Only `rst` clears `underflow`.
- **Mispredicting resolve.** After the pop, all remaining entries are dropped: `tail` ← `head`+1, `count` ← 0. A push in the same cycle is discarded.
- **External flush.** All entries are dropped and `count` ← 0.
  - A simultaneous valid resolve is still processed: its update is emitted, then the queue is cleared.
  - A simultaneous push is discarded.
- **Push + resolve, same cycle, no mispredict, no flush.** `count` is unchanged. Push is permitted only when not full; a full queue does not accept a push even with a concurrent pop.
- **Priority per edge:** `rst` > (resolve, then flush/mispredict clear) > push.
- **Reset.** Pointers and `count` = 0, `empty`=1, `full`=0, `update`/`mispredict`/`actual`=0, `update_index`/`update_weight`=0, `underflow`=0, `push_ready`=0 while `rst` is high. Storage contents need not be reset.
- **Reset mid-operation.** All pending entries are lost and no update is emitted for them.

## Timing
- **Push to visibility:** 1 cycle. An entry pushed at edge N can be resolved in cycle N+1 (after edge N).
- **Resolve to update:** a resolve sampled at edge N produces `update` high for exactly cycle N..N+1. All update outputs are registered.
- **Back-to-back resolves:** produce back-to-back `update` pulses, with no bubble.
- **Combinational from state only:** `push_ready`, `count`, `empty`, `full`. There is no input-to-output combinational path except `rst` → `push_ready`.
- **`update` outputs between pulses:** hold their last value; consumers qualify them with `update`.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `push_valid`=1 → `push_ready`=0, `count`=0, `empty`=1, `update`=0 throughout. One cycle after release, `push_ready`=1.
- **Fill and drain:** push 4 entries (index 1..4, weight 2'b10, pred=1), then resolve 4 with taken=1 → `full`=1 after the 4th push. A 5th push sees `push_ready`=0. Four consecutive `update` pulses follow with index 1,2,3,4 and `mispredict`=0. Finally `empty`=1.
- **Mispredict squash:** push index 7 (pred=1), 8, 9. Resolve with taken=0 while pushing index 10 → next cycle `update`=1, index 7, `actual`=0, `mispredict`=1, and `count`=0. No further updates follow.
- **Flush with resolve:** push 2 entries (index 3, 5). Assert `flush` together with `resolve_valid` (taken=1, pred=1) → update for index 3 with `mispredict`=0, and `count`=0. Index 5 is never emitted.
- **Wrap-around:** sustain 1 push + 1 resolve per cycle for 10 cycles (indices 0..9, pred alternating, taken=pred) → updates appear in order 0..9 one cycle after each resolve. `count` stays 1 and `mispredict`=0.
- **Underflow:** resolve on an empty queue → `update`=0 and `underflow`=1. `underflow` stays set through later normal traffic and clears only on `rst`.
